// File: rtl/core_types_pkg.sv
// Shared RV32I core types: opcodes, ALU ops, immediate formats and decode control.
package core_types_pkg;

  localparam int N_BITS = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       op1_sel_pc;
    logic       op2_sel_imm;
    logic       rf_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic [2:0] mem_funct3;
    wb_sel_e    wb_sel;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

  // sub_en selects SUB for funct3 000; sra_en selects SRA for funct3 101
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                              input logic sub_en,
                                              input logic sra_en);
    case (funct3)
      3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/d_stage_if.sv
// Decode-stage bus: fetch-side inputs, execute-side outputs and the stall/squash/redirect handshake.
// Optional illegal_instr output is present when D_STAGE_ILLEGAL_INSTR_EN is defined.
interface d_stage_if;
  import core_types_pkg::*;

  logic [N_BITS-1:0] pc_in;
  logic [N_BITS-1:0] pc_plus4_in;
  logic [31:0]       instr_in;
  logic              vld_in;
  logic [N_BITS-1:0] pc;
  logic [N_BITS-1:0] pc_plus4;
  logic [31:0]       instr;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [4:0]        rd_addr;
  logic [N_BITS-1:0] imm;
  ctrl_t             ctrl;
  logic [N_BITS-1:0] jal_tgt;
  logic              jal_vld;
  logic [4:0]        ex_rd_addr;
  logic              ex_is_load;
  logic              ex_vld;
  logic              vld;
  logic              stall_in;
  logic              stall;
  logic              squash_in;
  logic              squash;
`ifdef D_STAGE_ILLEGAL_INSTR_EN
  logic              illegal_instr;
`endif

  modport master (
    output pc_in, pc_plus4_in, instr_in, vld_in, ex_rd_addr, ex_is_load, ex_vld,
           stall_in, squash_in,
    input  pc, pc_plus4, instr, rs1_addr, rs2_addr, rd_addr, imm, ctrl,
           jal_tgt, jal_vld, vld, stall, squash
`ifdef D_STAGE_ILLEGAL_INSTR_EN
    , input illegal_instr
`endif
  );

  modport slave (
    input  pc_in, pc_plus4_in, instr_in, vld_in, ex_rd_addr, ex_is_load, ex_vld,
           stall_in, squash_in,
    output pc, pc_plus4, instr, rs1_addr, rs2_addr, rd_addr, imm, ctrl,
           jal_tgt, jal_vld, vld, stall, squash
`ifdef D_STAGE_ILLEGAL_INSTR_EN
    , output illegal_instr
`endif
  );

endinterface

// File: rtl/d_stage_imm_gen.sv
// RV32I immediate generator: I/S/B/U/J formats, sign-extended from instr[31].
module d_imm_gen
  import core_types_pkg::*;
(
  input  logic [31:7]       instr_hi,
  input  imm_type_e         imm_type,
  output logic [N_BITS-1:0] imm
);

  logic s;
  assign s = instr_hi[31];

  always_comb begin
    case (imm_type)
      IMM_S:   imm = {{(N_BITS-12){s}}, instr_hi[31:25], instr_hi[11:7]};
      IMM_B:   imm = {{(N_BITS-12){s}}, instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};
      IMM_U:   imm = {instr_hi[31:12], 12'b0};
      IMM_J:   imm = {{(N_BITS-20){s}}, instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};
      default: imm = {{(N_BITS-12){s}}, instr_hi[31:20]};
    endcase
  end

endmodule

// File: rtl/d_stage.sv
// RV32I decode stage: pipeline register, control decode, load-use stall and in-decode JAL redirect.
// Define D_STAGE_ILLEGAL_INSTR_EN to expose the illegal_instr flag.
module d_stage
  import core_types_pkg::*;
#(
  parameter logic [31:0] RST_INSTR = NOP_INSTR
)(
  input logic     clk,
  input logic     rst,
  d_stage_if.slave bus
);

  logic [N_BITS-1:0] pc_q;
  logic [N_BITS-1:0] pc_plus4_q;
  logic [31:0]       instr_q;
  logic              vld_raw;
  ctrl_t             ctrl_d;
  imm_type_e         imm_type;
  logic              illegal;
  logic              gen_stall;
  logic [N_BITS-1:0] imm_j;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  opcode_e           opcode;

  // A stalled instruction stays in place until the hazard clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= RST_INSTR;
      vld_raw    <= 1'b0;
    end else if (!bus.stall) begin
      pc_q       <= bus.pc_in;
      pc_plus4_q <= bus.pc_plus4_in;
      instr_q    <= bus.instr_in;
      vld_raw    <= bus.vld_in;
    end
  end

  assign opcode = opcode_e'(instr_q[6:0]);
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  always_comb begin
    ctrl_d            = NOP_CTRL;
    ctrl_d.mem_funct3 = funct3;
    imm_type          = IMM_I;
    illegal           = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl_d.rf_wen = 1'b1; ctrl_d.op2_sel_imm = 1'b1; ctrl_d.alu_op = ALU_PASS_B;
        imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_d.rf_wen = 1'b1; ctrl_d.op1_sel_pc = 1'b1; ctrl_d.op2_sel_imm = 1'b1;
        imm_type = IMM_U;
      end
      OPC_JAL: begin
        ctrl_d.rf_wen = 1'b1; ctrl_d.op1_sel_pc = 1'b1; ctrl_d.op2_sel_imm = 1'b1;
        ctrl_d.wb_sel = WB_PC4; ctrl_d.is_jal = 1'b1;
        imm_type = IMM_J;
      end
      OPC_JALR: begin
        ctrl_d.rf_wen = 1'b1; ctrl_d.op2_sel_imm = 1'b1; ctrl_d.wb_sel = WB_PC4;
        ctrl_d.uses_rs1 = 1'b1; ctrl_d.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_d.alu_op = ALU_SUB; ctrl_d.uses_rs1 = 1'b1; ctrl_d.uses_rs2 = 1'b1;
        ctrl_d.is_branch = 1'b1;
        imm_type = IMM_B;
      end
      OPC_LOAD: begin
        ctrl_d.rf_wen = 1'b1; ctrl_d.mem_ren = 1'b1; ctrl_d.op2_sel_imm = 1'b1;
        ctrl_d.wb_sel = WB_MEM; ctrl_d.uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl_d.mem_wen = 1'b1; ctrl_d.op2_sel_imm = 1'b1;
        ctrl_d.uses_rs1 = 1'b1; ctrl_d.uses_rs2 = 1'b1;
        imm_type = IMM_S;
      end
      OPC_OP_IMM: begin
        ctrl_d.rf_wen = 1'b1; ctrl_d.op2_sel_imm = 1'b1; ctrl_d.uses_rs1 = 1'b1;
        ctrl_d.alu_op = alu_from_funct3(funct3, 1'b0, funct7[5]);
        illegal = (funct3 == 3'b001 && funct7 != 7'h00) ||
                  (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
      end
      OPC_OP: begin
        ctrl_d.rf_wen = 1'b1; ctrl_d.uses_rs1 = 1'b1; ctrl_d.uses_rs2 = 1'b1;
        ctrl_d.alu_op = alu_from_funct3(funct3, funct7[5], funct7[5]);
        illegal = funct7 != 7'h00 &&
                  !(funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl_d = NOP_CTRL;
    if (instr_q[11:7] == 5'd0) ctrl_d.rf_wen = 1'b0;
  end

  d_imm_gen u_imm_gen (
    .instr_hi (instr_q[31:7]),
    .imm_type (imm_type),
    .imm      (bus.imm)
  );

  // Dedicated J-immediate so the redirect target never depends on the decoded format
  d_imm_gen u_jal_imm (
    .instr_hi (instr_q[31:7]),
    .imm_type (IMM_J),
    .imm      (imm_j)
  );

  assign gen_stall = vld_raw && bus.ex_vld && bus.ex_is_load && bus.ex_rd_addr != 5'd0 &&
                     ((ctrl_d.uses_rs1 && bus.ex_rd_addr == instr_q[19:15]) ||
                      (ctrl_d.uses_rs2 && bus.ex_rd_addr == instr_q[24:20]));

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4_q;
  assign bus.instr    = instr_q;
  assign bus.rs1_addr = instr_q[19:15];
  assign bus.rs2_addr = instr_q[24:20];
  assign bus.rd_addr  = instr_q[11:7];
  assign bus.ctrl     = ctrl_d;
  assign bus.vld      = vld_raw && !gen_stall && !bus.squash_in;
  assign bus.stall    = gen_stall || bus.stall_in;
  assign bus.jal_tgt  = pc_q + imm_j;
  assign bus.jal_vld  = bus.vld && ctrl_d.is_jal && !bus.stall_in;
  assign bus.squash   = bus.squash_in || bus.jal_vld;

`ifdef D_STAGE_ILLEGAL_INSTR_EN
  assign bus.illegal_instr = bus.vld && illegal;
`endif

endmodule

// File: tb/tb_d_stage.sv
// Directed self-checking bench for d_stage: JAL redirect, load-use stall, squash, reset and immediates.
module tb_d_stage;
  import core_types_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  d_stage_if bus ();

  d_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc_v, input logic [31:0] instr_v,
                               input logic vld_v);
    bus.pc_in       = pc_v;
    bus.pc_plus4_in = pc_v + 32'd4;
    bus.instr_in    = instr_v;
    bus.vld_in      = vld_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst            = 1'b1;
    bus.ex_rd_addr = 5'd0;
    bus.ex_is_load = 1'b0;
    bus.ex_vld     = 1'b0;
    bus.stall_in   = 1'b0;
    bus.squash_in  = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("rst_pc", bus.pc, 32'h0);
    checkOutput("rst_instr", bus.instr, 32'h0000_0013);
    checkOutput("rst_vld", 32'(bus.vld), 32'd0);
    checkOutput("rst_squash", 32'(bus.squash), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // JAL x0, +16 at 0x100
    applyStimulus(32'h100, 32'h0100_006F, 1'b1);
    tick();
    applyStimulus(32'h104, 32'h0, 1'b0);
    checkOutput("jal_pc", bus.pc, 32'h100);
    checkOutput("jal_tgt", bus.jal_tgt, 32'h110);
    checkOutput("jal_vld", 32'(bus.jal_vld), 32'd1);
    checkOutput("jal_squash", 32'(bus.squash), 32'd1);
    checkOutput("jal_vld_out", 32'(bus.vld), 32'd1);
    checkOutput("jal_wb_sel", 32'(bus.ctrl.wb_sel), 32'd2);
    checkOutput("jal_rf_wen_x0", 32'(bus.ctrl.rf_wen), 32'd0);

    // squash from execute overrides the JAL
    bus.squash_in = 1'b1;
    #1;
    checkOutput("sq_vld", 32'(bus.vld), 32'd0);
    checkOutput("sq_jal_vld", 32'(bus.jal_vld), 32'd0);
    checkOutput("sq_squash", 32'(bus.squash), 32'd1);
    bus.squash_in = 1'b0;

    // stall from execute blocks the redirect
    bus.stall_in = 1'b1;
    #1;
    checkOutput("stin_jal_vld", 32'(bus.jal_vld), 32'd0);
    checkOutput("stin_stall", 32'(bus.stall), 32'd1);
    checkOutput("stin_squash", 32'(bus.squash), 32'd0);
    bus.stall_in = 1'b0;

    // ADDI x1, x0, -1
    applyStimulus(32'h104, 32'hFFF0_0093, 1'b1);
    tick();
    checkOutput("addi_imm", bus.imm, 32'hFFFF_FFFF);
    checkOutput("addi_rd", 32'(bus.rd_addr), 32'd1);
    checkOutput("addi_rf_wen", 32'(bus.ctrl.rf_wen), 32'd1);
    checkOutput("addi_op2_imm", 32'(bus.ctrl.op2_sel_imm), 32'd1);
    checkOutput("addi_vld", 32'(bus.vld), 32'd1);

    // ADDI x0 (canonical NOP)
    applyStimulus(32'h108, 32'h0000_0013, 1'b1);
    tick();
    checkOutput("nop_rf_wen", 32'(bus.ctrl.rf_wen), 32'd0);

    // ADD x6, x5, x7 with LW x5 in execute
    applyStimulus(32'h200, 32'h0072_8333, 1'b1);
    tick();
    applyStimulus(32'h204, 32'h0002_82B7, 1'b1);
    bus.ex_vld     = 1'b1;
    bus.ex_is_load = 1'b1;
    bus.ex_rd_addr = 5'd5;
    #1;
    checkOutput("lu_stall", 32'(bus.stall), 32'd1);
    checkOutput("lu_vld", 32'(bus.vld), 32'd0);
    checkOutput("lu_rs1", 32'(bus.rs1_addr), 32'd5);
    tick();
    bus.ex_vld = 1'b0;
    #1;
    checkOutput("lu_hold_pc", bus.pc, 32'h200);
    checkOutput("lu_hold_instr", bus.instr, 32'h0072_8333);
    checkOutput("lu_release_vld", 32'(bus.vld), 32'd1);
    checkOutput("lu_release_stall", 32'(bus.stall), 32'd0);

    // load into x0 never stalls
    bus.ex_vld     = 1'b1;
    bus.ex_rd_addr = 5'd0;
    #1;
    checkOutput("x0_stall", 32'(bus.stall), 32'd0);
    checkOutput("x0_vld", 32'(bus.vld), 32'd1);

    // LUI x5 (rs1 field = 5) ignores the load
    tick();
    bus.ex_rd_addr = 5'd5;
    #1;
    checkOutput("lui_instr", bus.instr, 32'h0002_82B7);
    checkOutput("lui_stall", 32'(bus.stall), 32'd0);
    checkOutput("lui_vld", 32'(bus.vld), 32'd1);
    checkOutput("lui_imm", bus.imm, 32'h0002_8000);
    bus.ex_vld = 1'b0;

    // unsupported opcode decodes to NOP control
    applyStimulus(32'h208, 32'h0000_037F, 1'b1);
    tick();
    checkOutput("bad_rf_wen", 32'(bus.ctrl.rf_wen), 32'd0);
    checkOutput("bad_mem", 32'({bus.ctrl.mem_ren, bus.ctrl.mem_wen}), 32'd0);

    // asynchronous reset mid-stream
    applyStimulus(32'h300, 32'h0072_8333, 1'b1);
    tick();
    checkOutput("pre_rst_vld", 32'(bus.vld), 32'd1);
    #2;
    bus.squash_in = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_vld", 32'(bus.vld), 32'd0);
    checkOutput("mid_rst_instr", bus.instr, 32'h0000_0013);
    checkOutput("mid_rst_pc", bus.pc, 32'h0);
    checkOutput("mid_rst_squash", 32'(bus.squash), 32'd1);
    bus.squash_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h304, 32'hFFF0_0093, 1'b1);
    #1;
    checkOutput("post_rst_vld0", 32'(bus.vld), 32'd0);
    tick();
    checkOutput("post_rst_vld1", 32'(bus.vld), 32'd1);
    checkOutput("post_rst_pc", bus.pc, 32'h304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_stage.md
Name: d_stage

Overview:
- Decode stage; sits directly downstream of the fetch stage and upstream of execute.
- Registers the fetched PC, PC+4, instruction word and valid bit, decodes RV32I control, generates immediates and detects load-use hazards.
- Resolves JAL in decode: the target and valid bit are returned to fetch, and the wrong-path fetch slot is squashed.
- Propagates stall and squash upstream using the same valid/stall/squash protocol as the other stages.

Parameters:
- N_BITS, 32 (core_types_pkg), datapath width.
- RST_INSTR, 32'h00000013, instruction register reset value (ADDI x0,x0,0 NOP).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pc_in  in  N_BITS  fetch PC
- pc_plus4_in  in  N_BITS  fetch PC+4
- instr_in  in  32  instruction memory read data for pc_in
- vld_in  in  1  fetch valid
- pc  out  N_BITS  registered PC
- pc_plus4  out  N_BITS  registered PC+4
- instr  out  32  registered instruction
- rs1_addr, rs2_addr, rd_addr  out  5 each  register addresses
- imm  out  N_BITS  sign-extended immediate
- ctrl  out  ctrl_t  decoded control struct
- jal_tgt  out  N_BITS  pc + J-immediate
- jal_vld  out  1  JAL redirect request to fetch
- ex_rd_addr  in  5  execute-stage rd
- ex_is_load  in  1  execute-stage instruction is a load
- ex_vld  in  1  execute-stage valid
- vld  out  1  valid to execute
- stall_in  in  1  stall from execute
- stall  out  1  stall to fetch
- squash_in  in  1  squash from execute (branch/JALR redirect)
- squash  out  1  squash to fetch

Behaviour:
- Pipeline register:
  - Load enable = !stall.
  - Captures pc_in, pc_plus4_in, instr_in and vld_in (into vld_raw).
  - Reset values: pc = 0, pc_plus4 = 0, instr = RST_INSTR, vld_raw = 0. Reset is asserted asynchronously and released synchronously to clk edges.
- Decode is purely combinational from instr; latency from fetch to execute is 1 cycle.
- Decode of opcode[6:0]:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP are decoded.
  - Any other opcode decodes to NOP ctrl: rf_wen = 0, mem_ren = 0, mem_wen = 0.
- Control fields:
  - rf_wen is forced to 0 when rd_addr == 0.
  - uses_rs1 and uses_rs2 are set per format: U and J formats use neither register; I format uses rs1 only.
- Immediates: I/S/B/U/J formats, each sign-extended from instr[31]. U format = {instr[31:12], 12'b0}.
- Load-use hazard: gen_stall = vld_raw && ex_vld && ex_is_load && ex_rd_addr != 0 && ((uses_rs1 && ex_rd_addr == rs1_addr) || (uses_rs2 && ex_rd_addr == rs2_addr)).
- Valid, stall and squash:
  - vld = vld_raw && !gen_stall && !squash_in. A stalled instruction emits a bubble and is held for the next cycle.
  - stall = gen_stall || stall_in.
  - jal_vld = vld && is_jal && !stall_in.
  - jal_tgt = pc + imm_J, wraps modulo 2^N_BITS.
  - gen_squash = jal_vld; squash = squash_in || gen_squash. This kills the fetch-stage instruction.
- Simultaneous events:
  - squash_in beats jal_vld: a squashed JAL issues no redirect.
  - stall_in blocks the JAL redirect; the redirect re-evaluates each cycle while the JAL is held.
  - A squash arriving during a stall kills vld that cycle; the held register contents become a bubble once vld_in = 0 is loaded.
- Reset mid-operation: all registers return to their reset values immediately, and vld = 0, jal_vld = 0 and squash = squash_in combinationally.

Optional Feature:
- Macro: D_STAGE_ILLEGAL_INSTR_EN.
- Defined: adds output illegal_instr (1 bit) = vld && (unsupported opcode || instr[1:0] != 2'b11 || illegal funct3/funct7 for OP/OP-IMM shifts). ctrl is still NOP for these instructions.
- Undefined: the port is absent and illegal encodings silently decode as NOP.

Decomposition:
- core_types_pkg gains:
  - opcode_e enum (7-bit)
  - alu_op_e enum (4-bit)
  - imm_type_e enum (I/S/B/U/J)
  - wb_sel_e enum (ALU/MEM/PC4)
  - ctrl_t packed struct: alu_op, op1_sel_pc, op2_sel_imm, rf_wen, mem_ren, mem_wen, mem_funct3, wb_sel, uses_rs1, uses_rs2, is_jal, is_jalr, is_branch
  - constant NOP_INSTR
- Sub-module d_imm_gen: instr[31:7] and imm_type_e in, N_BITS immediate out.

Test Plan:
- JAL at pc=0x100, instr=32'h0100006F -> next cycle jal_tgt=0x110, jal_vld=1, squash=1, vld=1, ctrl.wb_sel=PC4.
- LW x5 in execute (ex_is_load=1, ex_rd_addr=5, ex_vld=1), D holds ADD x6,x5,x7 -> stall=1, vld=0 for 1 cycle; pc and instr held; next cycle vld=1.
- Same as previous with ex_rd_addr=0, or D holds LUI x5 -> stall=0, vld=1.
- squash_in=1 while D holds a JAL -> vld=0, jal_vld=0, squash=1.
- rst asserted mid-stream with vld_raw=1 -> vld=0 and instr=0x00000013 asynchronously; after release, first vld_in=1 appears on vld 1 cycle later.
- ADDI with imm=-1 (32'hFFF00093) -> imm=32'hFFFFFFFF, rd_addr=1, ctrl.rf_wen=1, op2_sel_imm=1; ADDI x0 (32'h00000013) -> rf_wen=0.
